// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Shift-add multiplier and restoring divider; fixed WIDTH+2 cycle latency.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_abort,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_spec;
  logic [WIDTH-1:0]   r_spec_val;
  logic               r_dbz_pend;
  logic [WIDTH-1:0]   r_result;
  logic               r_dbz;

  logic               w_accept;
  logic               w_last;
  logic               w_sgn_a;
  logic               w_sgn_b;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic               w_bz;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_spec_val;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_dtrial;
  logic               w_dge;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_sel;

  assign o_ready       = (r_state == S_IDLE) || (r_state == S_DONE);
  assign o_done        = (r_state == S_DONE);
  assign o_result      = r_result;
  assign o_div_by_zero = r_dbz;

  assign w_accept = o_ready & i_start & ~i_abort;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  assign w_sgn_a = (i_op == 3'b001) || (i_op == 3'b010) ||
                   (i_op == 3'b100) || (i_op == 3'b110);
  assign w_sgn_b = (i_op == 3'b001) || (i_op == 3'b100) ||
                   (i_op == 3'b110);
  assign w_neg_a = w_sgn_a & i_a[WIDTH-1];
  assign w_neg_b = w_sgn_b & i_b[WIDTH-1];
  assign w_ma    = w_neg_a ? -i_a : i_a;
  assign w_mb    = w_neg_b ? -i_b : i_b;

  assign w_bz  = i_op[2] & ~|i_b;
  assign w_ovf = ((i_op == 3'b100) || (i_op == 3'b110)) &&
                 (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&i_b);

  always_comb begin
    w_spec_val = '0;
    if (w_bz)
      w_spec_val = i_op[1] ? i_a : '1;
    else if (w_ovf)
      w_spec_val = i_op[1] ? '0 : i_a;
  end

  // Multiply: acc = {partial, multiplier}; add into top, shift right.
  assign w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                  (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; trial subtract.
  assign w_dtrial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_dge    = ~w_dtrial[WIDTH];
  assign w_div_next = {
    w_dge ? w_dtrial[WIDTH-1:0] : r_acc[2*WIDTH-2:WIDTH-1],
    r_acc[WIDTH-2:0],
    w_dge
  };

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH]
                          : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_sel = w_rem;
    unique case (r_op)
      3'b000:                 w_sel = w_prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_sel = w_prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_sel = w_quot;
      default:                w_sel = w_rem;
    endcase
    if (r_spec)
      w_sel = r_spec_val;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: w_next = w_accept ? S_CALC : S_IDLE;
      S_CALC: begin
        if (i_abort)
          w_next = S_IDLE;
        else if (w_last)
          w_next = S_FIXUP;
      end
      S_FIXUP: w_next = i_abort ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_spec     <= 1'b0;
      r_spec_val <= '0;
      r_dbz_pend <= 1'b0;
      r_result   <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op       <= i_op;
        r_neg_q    <= w_neg_a ^ w_neg_b;
        r_neg_r    <= w_neg_a;
        r_opnd     <= i_op[2] ? w_mb : w_ma;
        r_acc      <= {{WIDTH{1'b0}}, i_op[2] ? w_ma : w_mb};
        r_cnt      <= '0;
        r_spec     <= w_bz | w_ovf;
        r_spec_val <= w_spec_val;
        r_dbz_pend <= w_bz;
      end else if (r_state == S_CALC && !i_abort) begin
        r_acc <= r_op[2] ? w_div_next : w_mul_next;
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_FIXUP && !i_abort) begin
        r_result <= w_sel;
        r_dbz    <= r_dbz_pend;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit implementing the full RISC-V M-extension operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over a WIDTH-bit datapath. It replaces the single-cycle combinational `*` and `/` ALU paths with a shift-add multiplier and a restoring divider that take a fixed, bounded number of cycles, so the core's critical path no longer contains a full-width multiplier or divider. It sits beside the ALU in the datapath. The controller starts it with `start` and stalls the PC until `done`.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 4
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- start  in  1  request; accepted only when ready=1
- op  in  3  operation, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  WIDTH  operand rs1 (multiplicand / dividend)
- b  in  WIDTH  operand rs2 (multiplier / divisor)
- abort  in  1  cancel in-flight operation (pipeline flush)
- ready  out  1  unit can accept start this cycle
- done  out  1  one-cycle pulse: result valid
- result  out  WIDTH  result of last completed operation
- div_by_zero  out  1  qualifies done: last op was DIV/DIVU/REM/REMU with b=0

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- ready=1 in IDLE and DONE, 0 in CALC and FIXUP.
- Accept (start=1 & ready=1): latch op, a, b. Latch operand signs per op:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - All others: unsigned.
- Accept then converts signed operands to magnitudes, clears the 2·WIDTH accumulator and step counter, and goes to CALC.
- CALC, multiply: one shift-add step per cycle, LSB-first on the multiplier; WIDTH cycles.
- CALC, divide: one restoring step per cycle, MSB-first, producing one quotient bit per cycle; WIDTH cycles.
- After the last CALC step the unit goes to FIXUP.
- FIXUP negates the product, quotient and remainder as needed:
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- FIXUP then selects the output word:
  - MUL: low half of the product.
  - MULH, MULHSU, MULHU: high half of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- FIXUP registers result, then the unit goes to DONE.
- DONE: done=1 for that single cycle.
  - start=1 in DONE is accepted and the unit goes to CALC; otherwise it goes to IDLE.
- Special cases are resolved at accept; the unit still passes through CALC/FIXUP so latency stays fixed.
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give a; div_by_zero=1.
  - Signed overflow (DIV/REM, a = most-negative value, b = all-ones): DIV gives a; REM gives 0.
- Arithmetic is modulo 2^WIDTH. Negation is two's complement. The most-negative value has magnitude 2^(WIDTH-1), held in WIDTH bits, unsigned.
- abort=1 in CALC or FIXUP: go to IDLE next edge, no done, result and div_by_zero unchanged.
- abort=1 in IDLE or DONE: no effect, except that abort has priority over a same-cycle start, which is dropped.
- start while ready=0: ignored, not queued.
- result and div_by_zero hold their values until the next done.

## Timing
- Reset values: state IDLE, ready=1, done=0, result=0, div_by_zero=0.
- reset overrides start and abort. reset mid-operation returns the unit to reset values on the next edge with no done.
- Latency: start accepted at edge k → CALC for edges k+1..k+WIDTH → FIXUP at edge k+WIDTH+1 → done=1 in the cycle following edge k+WIDTH+1.
  - Total is WIDTH+2 cycles from accept to done; 34 for WIDTH=32.
  - The same latency applies to every op and to special cases.
- Back-to-back: start held high in DONE gives one op every WIDTH+2 cycles with no idle bubble.
- Operands a, b and op are sampled only at accept. They may change freely afterwards.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MUL a=7, b=6 → done exactly 34 cycles after accept; result=0x0000002A; div_by_zero=0.
- MULH a=0xFFFFFFFD (−3), b=5 → result=0xFFFFFFFF. MULHU with the same operands → 0x00000004. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU a=100, b=7 → 14. REMU a=100, b=7 → 2.
- DIVU a=100, b=0 → result=0xFFFFFFFF, div_by_zero=1. REM a=100, b=0 → 100. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- abort at cycle 10 of CALC → no done, ready=1 next cycle, result keeps its prior value. A new MUL 3×3 then gives 9 after 34 cycles. reset asserted mid-CALC → all outputs at reset values next cycle.
- start held high through a DONE cycle with a new op → second done exactly 34 cycles after the first. start while busy → ignored, no extra done. Rerun the MUL 7×6 and DIV −7/2 cases with WIDTH=8: latency 10, results 0x2A and 0xFD.
